// File: rtl/ps2_note_allocator.sv
// PS/2 keyboard note allocator: decodes scan-code bytes into note key presses and
// releases, and assigns each held note to one of NUM_VOICES voices.
// Optional feature macro: PS2_OCTAVE_SHIFT_EN enables Z (1A) / X (22) octave shift keys.
module ps2_note_allocator #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned DEFAULT_OCTAVE = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [7:0]                received_data,
  input  logic                      received_data_en,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [4*NUM_VOICES-1:0]   voice_note,
  output logic [3*NUM_VOICES-1:0]   voice_octave,
  output logic                      note_on,
  output logic                      note_off,
  output logic [2:0]                event_voice,
  output logic                      overflow,
  output logic [2:0]                octave
);

  typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

  state_e     state;
  logic       code_valid;
  logic [3:0] code_note;
  logic       hit;
  logic [2:0] hit_idx;
  logic       free;
  logic [2:0] free_idx;

  // Translate the incoming byte into a note index (valid only for the twelve note keys)
  always_comb begin
    code_valid = 1'b1;
    code_note  = 4'd0;
    case (received_data)
      8'h1C:   code_note = 4'd0;
      8'h1D:   code_note = 4'd1;
      8'h1B:   code_note = 4'd2;
      8'h24:   code_note = 4'd3;
      8'h23:   code_note = 4'd4;
      8'h2B:   code_note = 4'd5;
      8'h2C:   code_note = 4'd6;
      8'h34:   code_note = 4'd7;
      8'h35:   code_note = 4'd8;
      8'h33:   code_note = 4'd9;
      8'h3C:   code_note = 4'd10;
      8'h3B:   code_note = 4'd11;
      default: code_valid = 1'b0;
    endcase
  end

  // Find the voice already holding this note and the lowest-index free voice
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 3'd0;
    free     = 1'b0;
    free_idx = 3'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!hit && voice_active[i] && (voice_note[4*i +: 4] == code_note)) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      if (!free && !voice_active[i]) begin
        free     = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  // Parser FSM plus voice table; every output is registered (latency of one cycle)
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      voice_active <= '0;
      voice_note   <= '0;
      voice_octave <= '0;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      overflow     <= 1'b0;
      event_voice  <= 3'd0;
      octave       <= 3'(DEFAULT_OCTAVE);
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      overflow <= 1'b0;
      if (received_data_en) begin
        case (state)
          StIdle: begin
            if (received_data == 8'hF0) begin
              state <= StBreak;
            end else if (received_data == 8'hE0) begin
              state <= StExt;
            end else
`ifdef PS2_OCTAVE_SHIFT_EN
            if (received_data == 8'h1A) begin
              if (octave != 3'd0) octave <= octave - 3'd1;
            end else if (received_data == 8'h22) begin
              if (octave != 3'd7) octave <= octave + 3'd1;
            end else
`endif
            if (code_valid && !hit) begin
              // Held notes are typematic repeats and are silently ignored
              if (free) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                  if (3'(i) == free_idx) begin
                    voice_active[i]         <= 1'b1;
                    voice_note[4*i +: 4]    <= code_note;
                    voice_octave[3*i +: 3]  <= octave;
                  end
                end
                note_on     <= 1'b1;
                event_voice <= free_idx;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          StBreak: begin
            if (received_data != 8'hF0) begin
              state <= StIdle;
              if (code_valid && hit) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                  if (3'(i) == hit_idx) voice_active[i] <= 1'b0;
                end
                note_off    <= 1'b1;
                event_voice <= hit_idx;
              end
            end
          end
          StExt: begin
            state <= (received_data == 8'hF0) ? StExtBreak : StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_allocator.sv
// Self-checking bench for ps2_note_allocator: directed scenarios plus random byte
// streams compared against a behavioural model of keys held and voices assigned.
module tb_ps2_note_allocator;

  localparam int NV      = 4;
  localparam int DEF_OCT = 4;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx;
  logic              rx_en;
  logic [NV-1:0]     voice_active;
  logic [4*NV-1:0]   voice_note;
  logic [3*NV-1:0]   voice_octave;
  logic              note_on;
  logic              note_off;
  logic [2:0]        event_voice;
  logic              overflow;
  logic [2:0]        octave;

  int checks;
  int fails;

  // Behavioural model state
  bit m_active[NV];
  int m_note[NV];
  int m_oct[NV];
  int m_octave;
  bit m_e0;
  bit m_f0;
  bit exp_on;
  bit exp_off;
  bit exp_ovf;
  int exp_ev;

  ps2_note_allocator #(
    .NUM_VOICES    (NV),
    .DEFAULT_OCTAVE(DEF_OCT)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst_n),
    .received_data   (rx),
    .received_data_en(rx_en),
    .voice_active    (voice_active),
    .voice_note      (voice_note),
    .voice_octave    (voice_octave),
    .note_on         (note_on),
    .note_off        (note_off),
    .event_voice     (event_voice),
    .overflow        (overflow),
    .octave          (octave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int map_code(input logic [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h1D: return 1;
      8'h1B: return 2;
      8'h24: return 3;
      8'h23: return 4;
      8'h2B: return 5;
      8'h2C: return 6;
      8'h34: return 7;
      8'h35: return 8;
      8'h33: return 9;
      8'h3C: return 10;
      8'h3B: return 11;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] exp_pulse();
    return {exp_on, exp_off, exp_ovf};
  endfunction

  function automatic logic [NV-1:0] exp_active();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_active[i];
    return v;
  endfunction

  function automatic logic [4*NV-1:0] exp_notes();
    logic [4*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[4*i +: 4] = 4'(m_note[i]);
    return v;
  endfunction

  function automatic logic [3*NV-1:0] exp_octs();
    logic [3*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[3*i +: 3] = 3'(m_oct[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_active[i] = 1'b0;
      m_note[i]   = 0;
      m_oct[i]    = 0;
    end
    m_octave = DEF_OCT;
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    exp_on = 1'b0;
    exp_off = 1'b0;
    exp_ovf = 1'b0;
    exp_ev = 0;
  endtask

  task automatic model_make(input logic [7:0] b);
    int n;
`ifdef PS2_OCTAVE_SHIFT_EN
    if (b == 8'h1A) begin
      if (m_octave > 0) m_octave--;
      return;
    end
    if (b == 8'h22) begin
      if (m_octave < 7) m_octave++;
      return;
    end
`endif
    n = map_code(b);
    if (n < 0) return;
    for (int i = 0; i < NV; i++) if (m_active[i] && m_note[i] == n) return;
    for (int i = 0; i < NV; i++) begin
      if (!m_active[i]) begin
        m_active[i] = 1'b1;
        m_note[i]   = n;
        m_oct[i]    = m_octave;
        exp_on      = 1'b1;
        exp_ev      = i;
        return;
      end
    end
    exp_ovf = 1'b1;
  endtask

  task automatic model_break(input logic [7:0] b);
    int n;
    n = map_code(b);
    if (n < 0) return;
    for (int i = 0; i < NV; i++) begin
      if (m_active[i] && m_note[i] == n) begin
        m_active[i] = 1'b0;
        exp_off     = 1'b1;
        exp_ev      = i;
        return;
      end
    end
  endtask

  // Prefix tracking: E0 starts an ignored extended code, F0 marks a release
  task automatic model_byte(input logic [7:0] b);
    exp_on = 1'b0;
    exp_off = 1'b0;
    exp_ovf = 1'b0;
    if (m_e0) begin
      if (b == 8'hF0 && !m_f0) m_f0 = 1'b1;
      else begin
        m_e0 = 1'b0;
        m_f0 = 1'b0;
      end
    end else if (m_f0) begin
      if (b != 8'hF0) begin
        m_f0 = 1'b0;
        model_break(b);
      end
    end else if (b == 8'hF0) m_f0 = 1'b1;
    else if (b == 8'hE0) m_e0 = 1'b1;
    else model_make(b);
  endtask

  // One strobed byte; on return the registered response is visible
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx    = b;
    rx_en = 1'b1;
    model_byte(b);
    @(negedge clk);
    rx_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_en = 1'b0;
    model_reset();
    #2;
    checks++; if (voice_active !== '0) begin fails++; $display("FAIL reset_active got %b want 0", voice_active); end
    checks++; if (voice_note !== '0) begin fails++; $display("FAIL reset_note got %h want 0", voice_note); end
    checks++; if (voice_octave !== '0) begin fails++; $display("FAIL reset_voct got %h want 0", voice_octave); end
    checks++; if ({note_on, note_off, overflow} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {note_on, note_off, overflow}); end
    checks++; if (event_voice !== 3'd0) begin fails++; $display("FAIL reset_ev got %0d want 0", event_voice); end
    checks++; if (octave !== 3'(DEF_OCT)) begin fails++; $display("FAIL reset_octave got %0d want %0d", octave, DEF_OCT); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_press_release();
    do_reset();
    drive_byte(8'h1C);
    checks++; if (note_on !== 1'b1 || event_voice !== 3'd0) begin fails++; $display("FAIL press_on got on=%b ev=%0d want on=1 ev=0", note_on, event_voice); end
    checks++; if (voice_note[3:0] !== 4'd0 || voice_octave[2:0] !== 3'(DEF_OCT)) begin fails++; $display("FAIL press_voice got note=%0d oct=%0d want 0/%0d", voice_note[3:0], voice_octave[2:0], DEF_OCT); end
    @(negedge clk);
    checks++; if (note_on !== 1'b0) begin fails++; $display("FAIL press_pulse_width got on=%b want 0", note_on); end
    drive_byte(8'hF0);
    drive_byte(8'h1C);
    checks++; if (note_off !== 1'b1 || event_voice !== 3'd0) begin fails++; $display("FAIL release_off got off=%b ev=%0d want off=1 ev=0", note_off, event_voice); end
    checks++; if (voice_active !== '0) begin fails++; $display("FAIL release_active got %b want 0", voice_active); end
  endtask

  task automatic test_typematic();
    int ons;
    do_reset();
    ons = 0;
    for (int k = 0; k < 3; k++) begin
      drive_byte(8'h1C);
      if (note_on) ons++;
    end
    checks++; if (ons != 1) begin fails++; $display("FAIL typematic_ons got %0d want 1", ons); end
    checks++; if (voice_active !== 4'b0001) begin fails++; $display("FAIL typematic_active got %b want 0001", voice_active); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes[4] = '{8'h1C, 8'h1D, 8'h1B, 8'h24};
    do_reset();
    foreach (codes[k]) drive_byte(codes[k]);
    drive_byte(8'h23);
    checks++; if ({note_on, note_off, overflow} !== 3'b001) begin fails++; $display("FAIL overflow_pulse got %b want 001", {note_on, note_off, overflow}); end
    checks++; if (voice_active !== 4'b1111 || voice_note !== exp_notes()) begin fails++; $display("FAIL overflow_state got %b/%h want 1111/%h", voice_active, voice_note, exp_notes()); end
    drive_byte(8'hF0);
    drive_byte(8'h1D);
    checks++; if (note_off !== 1'b1 || event_voice !== 3'd1) begin fails++; $display("FAIL overflow_release got off=%b ev=%0d want 1/1", note_off, event_voice); end
    drive_byte(8'h23);
    checks++; if (note_on !== 1'b1 || event_voice !== 3'd1 || voice_note[7:4] !== 4'd4) begin fails++; $display("FAIL overflow_realloc got on=%b ev=%0d note=%0d want 1/1/4", note_on, event_voice, voice_note[7:4]); end
  endtask

  task automatic test_extended();
    logic [7:0] seq[5] = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C};
    int pulses;
    do_reset();
    pulses = 0;
    foreach (seq[k]) begin
      drive_byte(seq[k]);
      if (note_on || note_off || overflow) pulses++;
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL extended_pulses got %0d want 0", pulses); end
    drive_byte(8'h1C);
    checks++; if (note_on !== 1'b1 || voice_active !== 4'b0001) begin fails++; $display("FAIL extended_after got on=%b act=%b want 1/0001", note_on, voice_active); end
  endtask

  task automatic test_octave_keys();
    do_reset();
`ifdef PS2_OCTAVE_SHIFT_EN
    for (int k = 0; k < 4; k++) drive_byte(8'h22);
    checks++; if (octave !== 3'd7) begin fails++; $display("FAIL octave_sat got %0d want 7", octave); end
    drive_byte(8'h1C);
    checks++; if (voice_octave[2:0] !== 3'd7) begin fails++; $display("FAIL octave_capture got %0d want 7", voice_octave[2:0]); end
    drive_byte(8'h1A);
    checks++; if (octave !== 3'd6 || voice_octave[2:0] !== 3'd7) begin fails++; $display("FAIL octave_down got %0d/%0d want 6/7", octave, voice_octave[2:0]); end
    for (int k = 0; k < 8; k++) drive_byte(8'h1A);
    checks++; if (octave !== 3'd0) begin fails++; $display("FAIL octave_floor got %0d want 0", octave); end
`else
    drive_byte(8'h22);
    checks++; if (octave !== 3'(DEF_OCT) || note_on !== 1'b0) begin fails++; $display("FAIL octave_fixed_x got oct=%0d on=%b want %0d/0", octave, note_on, DEF_OCT); end
    drive_byte(8'h1A);
    checks++; if (octave !== 3'(DEF_OCT) || voice_active !== '0) begin fails++; $display("FAIL octave_fixed_z got oct=%0d act=%b want %0d/0", octave, voice_active, DEF_OCT); end
`endif
  endtask

  task automatic test_reset_mid_break();
    do_reset();
    drive_byte(8'h1C);
    drive_byte(8'hF0);
    do_reset();
    drive_byte(8'h1C);
    checks++; if ({note_on, note_off, overflow} !== 3'b100 || voice_active !== 4'b0001) begin fails++; $display("FAIL reset_mid got %b act=%b want 100/0001", {note_on, note_off, overflow}, voice_active); end
  endtask

  task automatic test_random();
    logic [7:0] keys[12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                             8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
    logic [7:0] junk[6]  = '{8'hAA, 8'hFA, 8'hFE, 8'h1A, 8'h22, 8'h15};
    logic [7:0] b;
    int r;
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(99));
      if (r < 55) b = keys[$urandom_range(5)];
      else if (r < 60) b = keys[$urandom_range(11)];
      else if (r < 82) b = 8'hF0;
      else if (r < 88) b = 8'hE0;
      else if (r < 96) b = junk[$urandom_range(5)];
      else b = 8'($urandom);
      drive_byte(b);
      checks++;
      if ({note_on, note_off, overflow} !== exp_pulse()) begin
        fails++; $display("FAIL rand_pulses byte=%h got %b want %b", b, {note_on, note_off, overflow}, exp_pulse());
      end
      if (exp_on || exp_off) begin
        checks++;
        if (event_voice !== 3'(exp_ev)) begin fails++; $display("FAIL rand_ev byte=%h got %0d want %0d", b, event_voice, exp_ev); end
      end
      checks++;
      if (voice_active !== exp_active() || voice_note !== exp_notes() ||
          voice_octave !== exp_octs() || octave !== 3'(m_octave)) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL rand_state byte=%h got %b/%h/%h/%0d want %b/%h/%h/%0d", b,
          voice_active, voice_note, voice_octave, octave, exp_active(), exp_notes(), exp_octs(), m_octave);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b1;
    rx     = 8'h00;
    rx_en  = 1'b0;
    model_reset();
    test_reset();
    test_press_release();
    test_typematic();
    test_overflow();
    test_extended();
    test_octave_keys();
    test_reset_mid_break();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
